lfsr_checker_param: RTL

- Parametrised successor to the team's 8-bit LFSR lock checker.
- Tracks a Galois LFSR stream of configurable width, polynomial and seed.
- Acquires lock after LOCK_CNT consecutive matches and drops lock after UNLOCK_CNT consecutive misses.
- Adds per-beat error reporting, saturating error and lock-loss counters, and a counter clear. Sits at the receive side of the PRBS test path, after the data sampler.

---
 rtl/lfsr_checker_param.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lfsr_checker_param.sv
// lfsr_checker_param - Galois LFSR lock checker on the receive side of the PRBS path.
//
// A local LFSR tracks the incoming PRBS word stream. After LOCK_CNT consecutive
// matching beats the checker locks. While locked, every mismatching beat raises a
// one-cycle error pulse. UNLOCK_CNT consecutive mismatches drop lock. Two
// saturating counters record errors and lock losses.
//
// Ports:
//   clock        rising-edge clock
//   rst          asynchronous active-high reset
//   soft_rst     synchronous clear; leaves the same state as rst
//   i_valid      qualifies i_data
//   i_data       received LFSR word
//   i_clr_cnt    synchronous clear of o_err_cnt / o_loss_cnt only
//   o_lock       1 while locked
//   o_err        1-cycle pulse: mismatching beat while locked
//   o_sync_loss  1-cycle pulse: lock dropped
//   o_err_cnt    saturating count of o_err pulses
//   o_loss_cnt   saturating count of lock losses
module lfsr_checker_param #(
  parameter int unsigned       WIDTH      = 8,
  parameter logic [WIDTH-1:0]  POLY       = 8'h1C,
  parameter logic [WIDTH-1:0]  SEED       = 8'hFF,
  parameter int unsigned       LOCK_CNT   = 5,
  parameter int unsigned       UNLOCK_CNT = 3,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             soft_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clr_cnt,
  output logic             o_lock,
  output logic             o_err,
  output logic             o_sync_loss,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_loss_cnt
);

  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned MissW  = $clog2(UNLOCK_CNT + 1);

  // Count value on the beat that completes the run.
  localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_CNT - 1);
  localparam logic [MissW-1:0]  MissLast  = MissW'(UNLOCK_CNT - 1);

  typedef enum logic {
    StUnlock,
    StLock
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   local_q, local_d;
  logic [MatchW-1:0]  match_cnt_q, match_cnt_d;
  logic [MissW-1:0]   miss_cnt_q, miss_cnt_d;
  logic               err_q, err_d;
  logic               sync_loss_q, sync_loss_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   loss_cnt_q, loss_cnt_d;

  logic               data_match;

  // Galois step. The zero-escape term splices the all-zero word into the
  // sequence so the period is the full 2^WIDTH.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
    logic             fb;
    logic [WIDTH-1:0] taps;
    fb   = x[WIDTH-1] ^ (x[WIDTH-2:0] == '0);
    taps = {POLY[WIDTH-1:1], 1'b0};
    return {x[WIDTH-2:0], fb} ^ (taps & {WIDTH{fb}});
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  assign data_match = (i_data == local_q);

  always_comb begin
    state_d     = state_q;
    local_d     = local_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = 1'b0;
    sync_loss_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    loss_cnt_d  = loss_cnt_q;

    // Clear first so a same-beat increment lands on zero.
    if (i_clr_cnt) begin
      err_cnt_d  = '0;
      loss_cnt_d = '0;
    end

    if (i_valid) begin
      unique case (state_q)
        StUnlock: begin
          if (data_match) begin
            local_d = lfsr_next(local_q);
            if (match_cnt_q == MatchLast) begin
              state_d     = StLock;
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + MatchW'(1);
            end
          end else begin
            // Resync onto the received word.
            local_d     = lfsr_next(i_data);
            match_cnt_d = '0;
          end
        end
        StLock: begin
          if (data_match) begin
            local_d    = lfsr_next(local_q);
            miss_cnt_d = '0;
          end else begin
            err_d     = 1'b1;
            err_cnt_d = sat_inc(err_cnt_d);
            if (miss_cnt_q == MissLast) begin
              state_d     = StUnlock;
              miss_cnt_d  = '0;
              local_d     = lfsr_next(i_data);
              sync_loss_d = 1'b1;
              loss_cnt_d  = sat_inc(loss_cnt_d);
            end else begin
              // Isolated errors do not disturb the local sequence.
              local_d    = lfsr_next(local_q);
              miss_cnt_d = miss_cnt_q + MissW'(1);
            end
          end
        end
        default: begin
          state_d = StUnlock;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= StUnlock;
      local_q     <= SEED;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_q       <= 1'b0;
      sync_loss_q <= 1'b0;
      err_cnt_q   <= '0;
      loss_cnt_q  <= '0;
    end else if (soft_rst) begin
      state_q     <= StUnlock;
      local_q     <= SEED;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_q       <= 1'b0;
      sync_loss_q <= 1'b0;
      err_cnt_q   <= '0;
      loss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      local_q     <= local_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_q       <= err_d;
      sync_loss_q <= sync_loss_d;
      err_cnt_q   <= err_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  assign o_lock      = (state_q == StLock);
  assign o_err       = err_q;
  assign o_sync_loss = sync_loss_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_loss_cnt  = loss_cnt_q;

endmodule
